regfile_banked: RTL
===================

REGFILE_BANKED -- requirements
Module: regfile_banked

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register.
REQ-002 Parameter ADDR_SIZE, default 4: register address width; register count N = 2**ADDR_SIZE.
REQ-003 Parameter NRP, default 4: number of independent read ports.
REQ-004 Parameter PC_RESET, default 0: value loaded into the PC on reset.
REQ-005 Parameter IRQ_VECTOR, default 1: value loaded into the PC on interrupt entry.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port wen, input, 1: write enable for register wa.
REQ-009 Port cen, input, 1: PC increment enable.
REQ-010 Port link, input, 1: write PC+1 into the current-bank LR (register N-2).
REQ-011 Port wa, input, ADDR_SIZE: write address.
REQ-012 Port din, input, WIDTH: write data.
REQ-013 Port ra, input, NRP*ADDR_SIZE: packed read addresses; port k uses bits [k*ADDR_SIZE +: ADDR_SIZE].
REQ-014 Port rdata, output, NRP*WIDTH: packed read data; port k on bits [k*WIDTH +: WIDTH].
REQ-015 Port irq_req, input, 1: interrupt request, level.
REQ-016 Port iret, input, 1: return from interrupt.
REQ-017 Port irq_ack, output, 1: one-cycle pulse on the cycle after interrupt entry.
REQ-018 Port mode, output, 1: 0 = USER, 1 = IRQ.
REQ-019 Ports pc, sp, lr, output, WIDTH each: PC, current-bank register N-3 and current-bank register N-2.

Function
REQ-020 Register N-1 SHALL be the PC; registers 0..N-2 SHALL be general storage; registers N-3 (SP) and N-2 (LR) SHALL have separate USER and IRQ copies, selected by mode.
REQ-021 Reads SHALL be combinational: address N-1 returns pc; any other address returns the current-bank copy.
REQ-022 Mode FSM: USER->IRQ when irq_req=1 in USER; IRQ->USER when iret=1 in IRQ; otherwise hold.
REQ-023 Interrupt entry cycle SHALL: save pc into LR_irq, load IRQ_VECTOR into the PC, set mode=IRQ, ignore wen, link and cen; irq_ack=1 on the next cycle only.
REQ-024 iret cycle in IRQ SHALL load the PC from LR_irq, set mode=USER and ignore wen, link and cen.
REQ-025 irq_req in IRQ SHALL be ignored (no nesting); iret in USER SHALL be ignored; irq_req held through iret SHALL re-enter on the first USER cycle.
REQ-026 PC update priority otherwise: wen with wa=N-1 loads din; else cen increments the PC modulo 2**WIDTH (all-ones wraps to 0).
REQ-027 link=1 SHALL write pc+1 (modulo 2**WIDTH) into the current-bank LR and suppress wen entirely that cycle; cen still applies.
REQ-028 wen to wa in 0..N-2 SHALL write din to the current-bank copy at the clock edge.
REQ-029 Bank switches SHALL take effect on the cycle after the mode transition; writes in the transition cycle are suppressed as specified in REQ-023 and REQ-024.

Reset
REQ-030 While reset=1: every register and bank copy SHALL be loaded with 0, the PC with PC_RESET, mode with USER and irq_ack with 0; reset overrides every other input.
REQ-031 Asserting reset in IRQ mode SHALL return the block to USER with no irq_ack pulse.

Configuration
REQ-032 With RFB_BYPASS_EN defined: a read port whose address equals wa while an accepted write is in progress SHALL return din, and an LR read during link SHALL return pc+1.
REQ-033 With RFB_BYPASS_EN undefined: reads SHALL always return the stored value.

Structure
REQ-034 Package rfb_pkg SHALL hold the mode encoding constants (MODE_USER, MODE_IRQ) and index helpers for PC, LR and SP relative to ADDR_SIZE.
REQ-035 The PC SHALL be a sub-module rfb_pc, a loadable counter with synchronous reset, load and increment.

Verification
REQ-036 Reset with PC_RESET=0x10, then cen for 3 cycles -> pc=0x13, mode=0, all reads 0.
REQ-037 wen wa=3 din=0xDEAD, then read on every port -> 0xDEAD; in the same cycle with bypass enabled, ra=3 returns 0xDEAD.
REQ-038 pc=0x40, link=1 and wen wa=2 in the same cycle -> lr=0x41 and r2 unchanged.
REQ-039 USER sp=0x100, pc=0x50, irq_req=1 -> next cycle pc=IRQ_VECTOR, mode=1, irq_ack=1, sp=0 (IRQ bank); iret=1 -> pc=0x50, mode=0, sp=0x100.
REQ-040 pc=0xFFFFFFFF with cen=1 -> pc=0; wen wa=N-1 with cen=1 -> pc=din.
REQ-041 Reset asserted in IRQ mode -> mode=0, irq_ack=0, pc=PC_RESET on the next cycle.

Source files
------------

// File: rtl/rfb_pkg.sv
// Shared mode encoding and architectural register index helpers for regfile_banked.
package rfb_pkg;

    typedef enum logic {
        MODE_USER = 1'b0,
        MODE_IRQ  = 1'b1
    } mode_e;

    function automatic int unsigned pc_idx(input int unsigned addr_size);
        return (32'd1 << addr_size) - 32'd1;
    endfunction

    function automatic int unsigned lr_idx(input int unsigned addr_size);
        return (32'd1 << addr_size) - 32'd2;
    endfunction

    function automatic int unsigned sp_idx(input int unsigned addr_size);
        return (32'd1 << addr_size) - 32'd3;
    endfunction

endpackage

// File: rtl/rfb_pc.sv
// Program counter: loadable, incrementing counter with synchronous reset.
module rfb_pc #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Load has priority over increment; increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/regfile_banked.sv
// Register file with PC, banked SP/LR (USER/IRQ) and single-level interrupt entry/return.
// Define RFB_BYPASS_EN to forward in-flight write/link data to the read ports.
module regfile_banked
    import rfb_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      ADDR_SIZE  = 4,
    parameter int unsigned      NRP        = 4,
    parameter logic [WIDTH-1:0] PC_RESET   = '0,
    parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wen,
    input  logic                     cen,
    input  logic                     link,
    input  logic [ADDR_SIZE-1:0]     wa,
    input  logic [WIDTH-1:0]         din,
    input  logic [NRP*ADDR_SIZE-1:0] ra,
    output logic [NRP*WIDTH-1:0]     rdata,
    input  logic                     irq_req,
    input  logic                     iret,
    output logic                     irq_ack,
    output logic                     mode,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         sp,
    output logic [WIDTH-1:0]         lr
);

    localparam int unsigned         N    = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] PC_A = ADDR_SIZE'(pc_idx(ADDR_SIZE));
    localparam logic [ADDR_SIZE-1:0] LR_A = ADDR_SIZE'(lr_idx(ADDR_SIZE));
    localparam logic [ADDR_SIZE-1:0] SP_A = ADDR_SIZE'(sp_idx(ADDR_SIZE));

    // Entries SP_A and LR_A of gpr hold the USER copies of SP/LR.
    logic [WIDTH-1:0] gpr_q [N-1];
    logic [WIDTH-1:0] gpr_d [N-1];
    logic [WIDTH-1:0] sp_irq_q, sp_irq_d;
    logic [WIDTH-1:0] lr_irq_q, lr_irq_d;
    mode_e            mode_q;
    logic             irq_ack_q;

    logic             entry, leave, xfer, wr_ok, link_ok;
    logic             pc_load, pc_inc_en;
    logic [WIDTH-1:0] pc_load_val, pc_plus1;

    always_comb begin
        entry     = !reset && (mode_q == MODE_USER) && irq_req;
        leave     = !reset && (mode_q == MODE_IRQ) && iret;
        xfer      = entry || leave;
        link_ok   = !reset && !xfer && link;
        wr_ok     = !reset && !xfer && !link && wen;
        pc_plus1  = pc + WIDTH'(1);
        pc_load   = entry || leave || (wr_ok && (wa == PC_A));
        pc_inc_en = cen && !xfer;
        pc_load_val = din;
        if (entry) begin
            pc_load_val = IRQ_VECTOR;
        end else if (leave) begin
            pc_load_val = lr_irq_q;
        end
    end

    // Next state of the banked storage for the current mode.
    always_comb begin
        gpr_d    = gpr_q;
        sp_irq_d = sp_irq_q;
        lr_irq_d = lr_irq_q;
        if (entry) begin
            lr_irq_d = pc;
        end
        if (wr_ok && (wa != PC_A)) begin
            if ((mode_q == MODE_IRQ) && (wa == SP_A)) begin
                sp_irq_d = din;
            end else if ((mode_q == MODE_IRQ) && (wa == LR_A)) begin
                lr_irq_d = din;
            end else begin
                gpr_d[wa] = din;
            end
        end
        if (link_ok) begin
            if (mode_q == MODE_IRQ) begin
                lr_irq_d = pc_plus1;
            end else begin
                gpr_d[LR_A] = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_q     <= '{default: '0};
            sp_irq_q  <= '0;
            lr_irq_q  <= '0;
            mode_q    <= MODE_USER;
            irq_ack_q <= 1'b0;
        end else begin
            gpr_q     <= gpr_d;
            sp_irq_q  <= sp_irq_d;
            lr_irq_q  <= lr_irq_d;
            irq_ack_q <= entry;
            if (entry) begin
                mode_q <= MODE_IRQ;
            end else if (leave) begin
                mode_q <= MODE_USER;
            end
        end
    end

    rfb_pc #(
        .WIDTH     (WIDTH),
        .RESET_VAL (PC_RESET)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc_en),
        .pc_o       (pc)
    );

    assign mode    = mode_q;
    assign irq_ack = irq_ack_q;
    assign sp      = (mode_q == MODE_IRQ) ? sp_irq_q : gpr_q[SP_A];
    assign lr      = (mode_q == MODE_IRQ) ? lr_irq_q : gpr_q[LR_A];

    // Combinational read ports.
    always_comb begin
        logic [ADDR_SIZE-1:0] a;
        logic [WIDTH-1:0]     v;
        rdata = '0;
        a     = '0;
        v     = '0;
        for (int k = 0; k < int'(NRP); k++) begin
            a = ra[k*ADDR_SIZE +: ADDR_SIZE];
            if (a == PC_A) begin
                v = pc;
            end else if (a == SP_A) begin
                v = sp;
            end else if (a == LR_A) begin
                v = lr;
            end else begin
                v = gpr_q[a];
            end
`ifdef RFB_BYPASS_EN
            if (wr_ok && (a == wa)) begin
                v = din;
            end
            if (link_ok && (a == LR_A)) begin
                v = pc_plus1;
            end
`endif
            rdata[k*WIDTH +: WIDTH] = v;
        end
    end

endmodule
